// File: rtl/mont_pkg.sv
// mont_pkg: shared constants and types for the Montgomery multiplier controller.
// Operand width N, adder width ADD_W, loop counter width and FSM state encoding.
package mont_pkg;

  localparam int N     = 512;
  localparam int ADD_W = N + 2;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    PRE_ISSUE,
    PRE_WAIT,
    LOOP_ISSUE,
    LOOP_WAIT,
    SUB_ISSUE,
    SUB_WAIT,
    DONE
  } state_e;

  // Encoding of the {a[i], q} pair that chooses the loop addend
  typedef enum logic [1:0] {
    OP_ZERO = 2'b00,
    OP_M    = 2'b01,
    OP_B    = 2'b10,
    OP_BM   = 2'b11
  } operand_e;

  // Widen an N-bit operand to the adder width with zero fill
  function automatic logic [ADD_W-1:0] zext(input logic [N-1:0] v);
    return {2'b00, v};
  endfunction

endpackage

// File: rtl/mont_operand_sel.sv
// mont_operand_sel: picks the per-iteration addend 0 / B / M / B+M
// from the scanned multiplier bit a[i] and the reduction bit q.
module mont_operand_sel
  import mont_pkg::*;
(
  input  logic             a_bit_i,
  input  logic             q_i,
  input  logic [N-1:0]     b_i,
  input  logic [N-1:0]     m_i,
  input  logic [ADD_W-1:0] bm_i,
  output logic [ADD_W-1:0] operand_o
);

  operand_e sel;

  assign sel = operand_e'({a_bit_i, q_i});

  // Four-way addend mux; B+M is the precomputed sum so both can be added in one op
  always_comb begin
    operand_o = '0;
    unique case (sel)
      OP_ZERO: operand_o = '0;
      OP_M:    operand_o = zext(m_i);
      OP_B:    operand_o = zext(b_i);
      OP_BM:   operand_o = bm_i;
      default: operand_o = '0;
    endcase
  end

endmodule

// File: rtl/mont_mult_ctrl.sv
// mont_mult_ctrl: radix-2 bit-serial Montgomery multiplier controller.
// Computes result = a*b*2^-N mod m by sequencing an external multi-cycle adder:
// one B+M precompute, N add-and-halve iterations, one conditional final subtract.
// Build option: define SKIP_ZERO_ADD_EN to let iterations with a zero addend
// halve C locally in a single cycle without using the adder.
module mont_mult_ctrl
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_m,
  output logic [N-1:0]     result,
  output logic             done,
  output logic             add_start,
  output logic             add_subtract,
  output logic             add_shift,
  output logic [ADD_W-1:0] add_in_a,
  output logic [ADD_W-1:0] add_in_b,
  input  logic [ADD_W:0]   add_result,
  input  logic             add_done
);

  state_e state_q, state_d;

  logic [N-1:0]     aOp_q, aOp_d;
  logic [N-1:0]     bOp_q, bOp_d;
  logic [N-1:0]     mOp_q, mOp_d;
  logic [ADD_W-1:0] bm_q, bm_d;
  logic [ADD_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [N-1:0]     result_q, result_d;
  logic             done_q, done_d;

  logic [ADD_W-1:0] addInA_q, addInA_d;
  logic [ADD_W-1:0] addInB_q, addInB_d;
  logic             addSub_q, addSub_d;
  logic             addShift_q, addShift_d;

  logic             addStart;
  logic             lastBit;
  logic             skipNow;
  logic             aBitNext;
  logic             qNext;
  logic [ADD_W-1:0] loopOperand;

  assign lastBit = (idx_q == CNT_W'(N - 1));

`ifdef SKIP_ZERO_ADD_EN
  // With a[i]=0 and C even, q is 0 and the addend is zero, so C>>1 needs no adder
  assign skipNow = (state_q == LOOP_ISSUE) && !aOp_q[idx_q] && !c_q[0];
`else
  assign skipNow = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: add_done only matters in WAIT states, start only in IDLE/DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = PRE_ISSUE;
      end
      PRE_ISSUE: state_d = PRE_WAIT;
      PRE_WAIT: begin
        if (add_done) state_d = LOOP_ISSUE;
      end
      LOOP_ISSUE: begin
        if (skipNow) state_d = lastBit ? SUB_ISSUE : LOOP_ISSUE;
        else         state_d = LOOP_WAIT;
      end
      LOOP_WAIT: begin
        if (add_done) state_d = lastBit ? SUB_ISSUE : LOOP_ISSUE;
      end
      SUB_ISSUE: state_d = SUB_WAIT;
      SUB_WAIT: begin
        if (add_done) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: one adder request per ISSUE cycle unless the iteration is handled locally
  always_comb begin
    addStart = 1'b0;
    unique case (state_q)
      PRE_ISSUE, SUB_ISSUE: addStart = 1'b1;
      LOOP_ISSUE:           addStart = !skipNow;
      default:              addStart = 1'b0;
    endcase
  end

  // Datapath next values: operand capture, B+M store, C/counter update, final select
  always_comb begin
    aOp_d    = aOp_q;
    bOp_d    = bOp_q;
    mOp_d    = mOp_q;
    bm_d     = bm_q;
    c_d      = c_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          aOp_d  = in_a;
          bOp_d  = in_b;
          mOp_d  = in_m;
          c_d    = '0;
          idx_d  = '0;
          done_d = 1'b0;
        end
      end
      PRE_WAIT: begin
        if (add_done) bm_d = add_result[ADD_W-1:0];
      end
      LOOP_ISSUE: begin
        if (skipNow) begin
          c_d = c_q >> 1;
          if (!lastBit) idx_d = idx_q + CNT_W'(1);
        end
      end
      LOOP_WAIT: begin
        if (add_done) begin
          c_d = add_result[ADD_W-1:0];
          if (!lastBit) idx_d = idx_q + CNT_W'(1);
        end
      end
      SUB_WAIT: begin
        if (add_done) begin
          result_d = add_result[ADD_W] ? add_result[N-1:0] : c_q[N-1:0];
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reduction bit and addend for the iteration about to be issued, from next-cycle values
  assign aBitNext = aOp_d[idx_d];
  assign qNext    = c_d[0] ^ (aBitNext & bOp_d[0]);

  mont_operand_sel u_operand_sel (
    .a_bit_i   (aBitNext),
    .q_i       (qNext),
    .b_i       (bOp_d),
    .m_i       (mOp_d),
    .bm_i      (bm_d),
    .operand_o (loopOperand)
  );

  // Adder operands load on entry to an ISSUE state and hold through the matching WAIT
  always_comb begin
    addInA_d   = addInA_q;
    addInB_d   = addInB_q;
    addSub_d   = addSub_q;
    addShift_d = addShift_q;
    unique case (state_d)
      PRE_ISSUE: begin
        addInA_d   = zext(bOp_d);
        addInB_d   = zext(mOp_d);
        addSub_d   = 1'b0;
        addShift_d = 1'b0;
      end
      LOOP_ISSUE: begin
        addInA_d   = c_d;
        addInB_d   = loopOperand;
        addSub_d   = 1'b0;
        addShift_d = 1'b1;
      end
      SUB_ISSUE: begin
        addInA_d   = c_d;
        addInB_d   = zext(mOp_d);
        addSub_d   = 1'b1;
        addShift_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and adder-interface registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      aOp_q      <= '0;
      bOp_q      <= '0;
      mOp_q      <= '0;
      bm_q       <= '0;
      c_q        <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      addInA_q   <= '0;
      addInB_q   <= '0;
      addSub_q   <= 1'b0;
      addShift_q <= 1'b0;
    end else begin
      aOp_q      <= aOp_d;
      bOp_q      <= bOp_d;
      mOp_q      <= mOp_d;
      bm_q       <= bm_d;
      c_q        <= c_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      done_q     <= done_d;
      addInA_q   <= addInA_d;
      addInB_q   <= addInB_d;
      addSub_q   <= addSub_d;
      addShift_q <= addShift_d;
    end
  end

  assign result       = result_q;
  assign done         = done_q;
  assign add_start    = addStart;
  assign add_subtract = addSub_q;
  assign add_shift    = addShift_q;
  assign add_in_a     = addInA_q;
  assign add_in_b     = addInB_q;

endmodule

// File: tb/tb_mont_mult_ctrl.sv
// tb_mont_mult_ctrl: scoreboard bench for mont_mult_ctrl with a behavioural
// multi-cycle adder attached downstream. Expected results come from plain
// modular arithmetic (a*b mod m, then N modular halvings).
`timescale 1ns/1ps
module tb_mont_mult_ctrl;

  localparam int N          = 512;
  localparam int ADD_W      = N + 2;
  localparam int CW         = 1024;
  localparam int LAT        = 2;
  localparam int FULL_LAT   = (1 + LAT) * (N + 2) + 1;
  localparam int NUM_RANDOM = 24;
`ifdef SKIP_ZERO_ADD_EN
  localparam int DEF_PULSES = -1;
  localparam int DEF_LAT    = -1;
`else
  localparam int DEF_PULSES = N + 2;
  localparam int DEF_LAT    = FULL_LAT;
`endif

  typedef struct {
    logic [N-1:0] res;
    int           pulses;
    int           lat;
    longint       startCyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N-1:0]     in_a, in_b, in_m;
  logic [N-1:0]     result;
  logic             done;
  logic             add_start, add_subtract, add_shift;
  logic [ADD_W-1:0] add_in_a, add_in_b;
  logic [ADD_W:0]   add_result;
  logic             add_done;

  logic [ADD_W:0]   addRes;
  int               addCnt;
  longint           cycleCount = 0;
  int               compared   = 0;
  int               mismatched = 0;
  exp_t             sbQ[$];
  exp_t             monE;
  logic [N-1:0]     curM;
  int               opPulses   = 0;
  logic             prevDone   = 1'b0;

  mont_mult_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_shift    (add_shift),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Downstream adder: result fixed at request time, add_done pulses LAT cycles later
  function automatic logic [ADD_W:0] adderFunc(input logic [ADD_W-1:0] x, input logic [ADD_W-1:0] y,
                                               input logic sub, input logic shf);
    logic [ADD_W:0] s;
    if (sub) begin
      s = {1'b0, x} + {1'b0, ~y} + (ADD_W + 1)'(1);
    end else begin
      s = {1'b0, x} + {1'b0, y};
      if (shf) s = s >> 1;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      addCnt <= 0;
      addRes <= '0;
    end else if (add_start) begin
      addCnt <= LAT;
      addRes <= adderFunc(add_in_a, add_in_b, add_subtract, add_shift);
    end else if (addCnt > 0) begin
      addCnt <= addCnt - 1;
    end
  end

  assign add_result = addRes;
  assign add_done   = (addCnt == 1);

  // Reference: (a*b mod m) multiplied by 2^-1 mod m, N times
  function automatic logic [N-1:0] refMont(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m);
    logic [2*N-1:0] p;
    logic [N+1:0]   x;
    p = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % {{N{1'b0}}, m};
    x = p[N+1:0];
    for (int k = 0; k < N; k++) begin
      if (x[0]) x = (x + {2'b00, m}) >> 1;
      else      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand512();
    logic [N-1:0] v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Issue one start pulse; called at a negedge, returns at the following negedge
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                               input int expPulses, input bit record);
    exp_t e;
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    curM  = m;
    if (record) begin
      e.res      = refMont(a, b, m);
      e.pulses   = expPulses;
      e.lat      = DEF_LAT;
      e.startCyc = cycleCount;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int budget = 0;
    while (sbQ.size() != 0 && budget < 4 * FULL_LAT) begin
      @(negedge clk);
      budget++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("wait_done_timeout", CW'(0), CW'(1));
      sbQ.delete();
    end
  endtask

  task automatic waitPulses(input int target);
    int seen   = 0;
    int budget = 0;
    while (seen < target && budget < 4 * FULL_LAT) begin
      if (add_start) seen++;
      if (seen < target) begin
        @(negedge clk);
        budget++;
      end
    end
    if (seen < target) checkOutput("pulse_wait_timeout", CW'(seen), CW'(target));
  endtask

  // Monitor: pops the scoreboard on every rising done and watches each loop request
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        opPulses = 0;
      end else begin
        if (add_start) begin
          opPulses++;
          if (add_shift) checkOutput("c_below_2m", CW'(add_in_a < {1'b0, curM, 1'b0}), CW'(1));
        end
        if (done && !prevDone) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected_done", CW'(1), CW'(0));
          end else begin
            monE = sbQ.pop_front();
            checkOutput("result", CW'(result), CW'(monE.res));
            if (monE.pulses >= 0) checkOutput("add_start_count", CW'(opPulses), CW'(monE.pulses));
            if (monE.lat >= 0) checkOutput("latency", CW'(cycleCount - monE.startCyc), CW'(monE.lat));
          end
          opPulses = 0;
        end
      end
      prevDone = done;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: cycle limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] a, b, m;
    int           cnt;
    reset = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    in_m  = '0;
    curM  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_done",     CW'(done),         CW'(0));
    checkOutput("reset_result",   CW'(result),       CW'(0));
    checkOutput("reset_start",    CW'(add_start),    CW'(0));
    checkOutput("reset_subtract", CW'(add_subtract), CW'(0));
    checkOutput("reset_shift",    CW'(add_shift),    CW'(0));
    checkOutput("reset_in_a",     CW'(add_in_a),     CW'(0));
    checkOutput("reset_in_b",     CW'(add_in_b),     CW'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed: a=3 b=5 m=2^512-1");
    a = N'(3); b = N'(5); m = '1;
    applyStimulus(a, b, m, DEF_PULSES, 1'b1);
    waitIdle();
    checkOutput("result_15", CW'(result), CW'(15));

    $display("[TB] directed: a=1 b=1 m=3");
    a = N'(1); b = N'(1); m = N'(3);
    applyStimulus(a, b, m, DEF_PULSES, 1'b1);
    waitIdle();
    checkOutput("result_1", CW'(result), CW'(1));

    $display("[TB] directed: b=0");
    a = rand512(); b = '0; m = rand512(); m[0] = 1'b1;
    applyStimulus(a, b, m, DEF_PULSES, 1'b1);
    waitIdle();

`ifdef SKIP_ZERO_ADD_EN
    $display("[TB] directed: a=0 with zero-add skipping");
    a = '0; m = rand512(); m[0] = 1'b1; b = rand512() % m;
    applyStimulus(a, b, m, 2, 1'b1);
    waitIdle();
`endif

    $display("[TB] reset during loop iteration 100");
    a = rand512(); m = rand512(); m[N-1] = 1'b1; m[0] = 1'b1; b = rand512() % m;
    applyStimulus(a, b, m, DEF_PULSES, 1'b0);
    waitPulses(102);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_done",   CW'(done),      CW'(0));
    checkOutput("abort_start",  CW'(add_start), CW'(0));
    checkOutput("abort_result", CW'(result),    CW'(0));
    checkOutput("abort_in_a",   CW'(add_in_a),  CW'(0));
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (add_start || done) cnt++;
    end
    checkOutput("quiet_after_reset", CW'(cnt), CW'(0));
    applyStimulus(a, b, m, DEF_PULSES, 1'b1);
    waitIdle();

    $display("[TB] second start while busy");
    a = rand512(); m = rand512(); m[0] = 1'b1; b = rand512() % m;
    applyStimulus(a, b, m, DEF_PULSES, 1'b1);
    waitPulses(50);
    @(negedge clk);
    in_a  = rand512();
    in_b  = rand512();
    in_m  = rand512() | N'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    $display("[TB] random operands");
    for (int t = 0; t < NUM_RANDOM; t++) begin
      m = rand512();
      if (t % 2 == 1) m = m >> $urandom_range(1, 500);
      else            m[N-1] = 1'b1;
      m[0] = 1'b1;
      b = rand512() % m;
      a = (t == 0) ? '1 : rand512();
      applyStimulus(a, b, m, DEF_PULSES, 1'b1);
      waitIdle();
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", CW'(sbQ.size()), CW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
